// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants for the data-memory responder: RV32I
//                load/store funct3 codes, FSM state encoding and the
//                width/size helpers used by dmem_resp and dmem_lane.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Bus and word geometry
    localparam int XLEN           = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int NBYTES_W       = 3;   // holds byte counts 0..4
    localparam int LAT_W          = 4;   // wait counter, LATENCY 0..15
    localparam int STATE_W        = 2;

    // RV32I load/store funct3 codes (stores use only B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp_if
//  Description : Request/response handshake bundle between the pipeline MEM
//                stage (master) and the data-memory responder (slave).
//  Signals     : req_valid/req_ready    request handshake
//                req_write              1 = store, 0 = load
//                req_addr[31:0]         byte address
//                req_funct3[2:0]        RV32I load/store funct3
//                req_wdata[31:0]        store data, low bytes used per width
//                resp_valid/resp_ready  response handshake
//                resp_rdata[31:0]       extended load result (0 otherwise)
//                resp_err               access rejected
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_resp_if;
    import dmem_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [XLEN-1:0] req_addr;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_funct3, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_funct3, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface : dmem_resp_if
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane
//  Description : Combinational width/lane decoder for one load/store.
//                Decodes funct3 into a byte count, checks funct3 legality
//                and alignment, masks the store data to the used bytes and
//                sign/zero-extends the raw read word.
//                The raw read word is the four bytes starting at the access
//                address (byte addr+i on lane i), so no lane rotation is
//                needed here for either aligned or misaligned accesses.
//  Macro       : DMEM_MISALIGN_EN - when defined, misaligned half/word
//                accesses are legal; otherwise they are rejected.
//  Ports       : i_write        1 = store, 0 = load
//                i_funct3       RV32I funct3
//                i_addr_lo      address bits [1:0]
//                i_wdata        store data
//                i_raw_rdata    bytes addr..addr+3 on lanes 0..3
//                o_nbytes       access width in bytes (0 for unknown funct3)
//                o_legal        funct3 (and alignment) legal
//                o_wbytes       store data with unused lanes cleared
//                o_ext_rdata    extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane
    import dmem_pkg::*;
(
    input  wire logic                i_write,
    input  wire logic [2:0]          i_funct3,
    input  wire logic [1:0]          i_addr_lo,
    input  wire logic [XLEN-1:0]     i_wdata,
    input  wire logic [XLEN-1:0]     i_raw_rdata,
    output logic      [NBYTES_W-1:0] o_nbytes,
    output logic                     o_legal,
    output logic      [XLEN-1:0]     o_wbytes,
    output logic      [XLEN-1:0]     o_ext_rdata
);

    logic                      w_f3_ok;
    logic                      w_aligned;
    logic [BYTES_PER_WORD-1:0] w_lane_mask;

    always_comb begin
        w_f3_ok     = 1'b0;
        w_aligned   = 1'b1;
        o_nbytes    = '0;
        w_lane_mask = '0;
        o_ext_rdata = '0;
        case (i_funct3)
            F3_B: begin
                w_f3_ok     = 1'b1;
                o_nbytes    = NBYTES_W'(1);
                w_lane_mask = 4'b0001;
                o_ext_rdata = {{24{i_raw_rdata[7]}}, i_raw_rdata[7:0]};
            end
            F3_H: begin
                w_f3_ok     = 1'b1;
                w_aligned   = ~i_addr_lo[0];
                o_nbytes    = NBYTES_W'(2);
                w_lane_mask = 4'b0011;
                o_ext_rdata = {{16{i_raw_rdata[15]}}, i_raw_rdata[15:0]};
            end
            F3_W: begin
                w_f3_ok     = 1'b1;
                w_aligned   = (i_addr_lo == 2'b00);
                o_nbytes    = NBYTES_W'(4);
                w_lane_mask = 4'b1111;
                o_ext_rdata = i_raw_rdata;
            end
            F3_BU: begin
                // Unsigned loads have no store counterpart
                w_f3_ok     = ~i_write;
                o_nbytes    = NBYTES_W'(1);
                w_lane_mask = 4'b0001;
                o_ext_rdata = {24'd0, i_raw_rdata[7:0]};
            end
            F3_HU: begin
                w_f3_ok     = ~i_write;
                w_aligned   = ~i_addr_lo[0];
                o_nbytes    = NBYTES_W'(2);
                w_lane_mask = 4'b0011;
                o_ext_rdata = {16'd0, i_raw_rdata[15:0]};
            end
            default: begin
                w_f3_ok = 1'b0;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_EN
    // Misaligned accesses are carried out byte-wise by the owner of the array
    assign o_legal = w_f3_ok;
`else
    assign o_legal = w_f3_ok & w_aligned;
`endif

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_wlane
        assign o_wbytes[8*gi +: 8] = w_lane_mask[gi] ? i_wdata[8*gi +: 8] : 8'h00;
    end

endmodule : dmem_lane
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_resp
//  Description : Data-memory responder. Owns a byte-addressed little-endian
//                memory and serves one load/store at a time over a
//                valid/ready request channel and a valid/ready response
//                channel, with LATENCY extra wait cycles per access.
//                FSM: IDLE -> (accept) WAIT -> (counter == 0, commit) RESP
//                     -> (resp_ready) IDLE.
//  Macro       : DMEM_MISALIGN_EN - enables byte-wise misaligned half/word
//                accesses (handled in dmem_lane legality).
//  Parameters  : DMEM_SIZE  memory size in bytes (power of two, >= 8)
//                LATENCY    extra wait cycles per access (0..15)
//  Ports       : clock      system clock
//                reset      synchronous active-high reset
//                bus        dmem_resp_if.slave request/response bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DMEM_SIZE = 4096,
    parameter int LATENCY   = 1
)
(
    input  wire logic  clock,
    input  wire logic  reset,
    dmem_resp_if.slave bus
);

    localparam int c_IDX_W = $clog2(DMEM_SIZE);

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] r_state;
    logic [LAT_W-1:0]   r_cnt;
    logic               r_write;
    logic [XLEN-1:0]    r_addr;
    logic [2:0]         r_funct3;
    logic [XLEN-1:0]    r_wdata;
    logic [XLEN-1:0]    r_rdata;
    logic               r_err;

    // Not reset: contents survive reset by design
    logic [7:0]         r_mem [DMEM_SIZE];

    // ------------------------------------------------------------------
    // Byte addressing: lane i always maps to address addr+i. The index is
    // taken modulo DMEM_SIZE so out-of-range requests never index past the
    // array; such requests are rejected by the range check before commit.
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_idx [BYTES_PER_WORD];
    logic [XLEN-1:0]    w_raw;

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_byte
        assign w_idx[gi]         = r_addr[c_IDX_W-1:0] + c_IDX_W'(gi);
        assign w_raw[8*gi +: 8]  = r_mem[w_idx[gi]];
    end

    // ------------------------------------------------------------------
    // Width decode, legality and extension
    // ------------------------------------------------------------------
    logic [NBYTES_W-1:0] w_nbytes;
    logic                w_lane_legal;
    logic [XLEN-1:0]     w_wbytes;
    logic [XLEN-1:0]     w_ext;

    dmem_lane u_lane (
        .i_write     (r_write),
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_addr[1:0]),
        .i_wdata     (r_wdata),
        .i_raw_rdata (w_raw),
        .o_nbytes    (w_nbytes),
        .o_legal     (w_lane_legal),
        .o_wbytes    (w_wbytes),
        .o_ext_rdata (w_ext)
    );

    // addr <= DMEM_SIZE - nbytes in plain 32-bit arithmetic; DMEM_SIZE >= 8
    // keeps the subtraction from underflowing, so high addresses such as
    // 0xFFFFFFFE cannot wrap into range.
    logic [XLEN-1:0] w_limit;
    logic            w_in_range;
    logic            w_ok;
    logic            w_commit;

    assign w_limit    = XLEN'(DMEM_SIZE) - {{(XLEN-NBYTES_W){1'b0}}, w_nbytes};
    assign w_in_range = (r_addr <= w_limit);
    assign w_ok       = w_lane_legal & w_in_range;
    assign w_commit   = (r_state == ST_WAIT) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // Handshake outputs (req_ready depends on state only)
    // ------------------------------------------------------------------
    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_addr   <= bus.req_addr;
                        r_funct3 <= bus.req_funct3;
                        r_wdata  <= bus.req_wdata;
                        r_cnt    <= LAT_W'(LATENCY);
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_err   <= ~w_ok;
                        r_rdata <= (w_ok && !r_write) ? w_ext : '0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Response data stays frozen until the consumer takes it
                    if (bus.resp_ready) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store commit. Gated by reset so an access abandoned by reset on the
    // commit edge leaves memory untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset && w_commit && w_ok && r_write) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (NBYTES_W'(i) < w_nbytes) begin
                    r_mem[w_idx[i]] <= w_wbytes[8*i +: 8];
                end
            end
        end
    end

endmodule : dmem_resp
`default_nettype wire
